// File: rtl/move_list_if.sv
// ============================================================================
// move_list_if : snapshot-in / move-out handshake bundle for move_list_collector
// Rev 1.0
// ============================================================================
`default_nettype none

interface move_list_if #(
  parameter int NDIR   = 16,
  parameter int MOVE_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NDIR*MOVE_W-1:0]   moves_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [MOVE_W-1:0]        out_move;

  // master: snapshot producer and move consumer (search engine side)
  modport master (
    output in_valid, moves_in, out_ready,
    input  in_ready, out_valid, out_move
  );

  modport slave (
    input  in_valid, moves_in, out_ready,
    output in_ready, out_valid, out_move
  );
endinterface

`default_nettype wire

// File: rtl/move_list_collector.sv
// ============================================================================
// move_list_collector : scans a 16-word move snapshot, queues nonzero words in a FWFT FIFO
// Option macro MOVE_LIST_DROP_ON_FULL_EN: drop (not stall) on full, adds drop_count.
// Rev 1.0
// ============================================================================
`default_nettype none

module move_list_collector #(
  parameter int NDIR   = 16,
  parameter int MOVE_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     clear,
  move_list_if.slave                    bus,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          busy,
  output logic [CNT_W-1:0]              move_count
`ifdef MOVE_LIST_DROP_ON_FULL_EN
  ,
  output logic [CNT_W-1:0]              drop_count
`endif
);

  localparam int IDX_W = $clog2(NDIR);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [NDIR*MOVE_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [MOVE_W-1:0]        mem_q [DEPTH];
  logic [MOVE_W-1:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [CNT_W-1:0]         move_count_q, move_count_d;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
  logic [CNT_W-1:0]         drop_count_q, drop_count_d;
  logic                     drop;
`endif

  logic [MOVE_W-1:0]        cur_word;
  logic                     word_nz;
  logic                     full;
  logic                     empty;
  logic                     scanning;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     advance;
  logic                     last;

  // Scan decision: the word under idx either gets pushed, skipped, dropped or stalls
  always_comb begin
    scanning = (state_q == S_SCAN);
    cur_word = snap_q[int'(idx_q)*MOVE_W +: MOVE_W];
    word_nz  = (cur_word != '0);
    full     = (level_q == LVL_W'(DEPTH));
    empty    = (level_q == '0);
    last     = (idx_q == IDX_W'(NDIR-1));
    accept   = (state_q == S_IDLE) && bus.in_valid;
    push     = scanning && word_nz && !full;
    pop      = !empty && bus.out_ready;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
    drop     = scanning && word_nz && full;
    advance  = scanning;
`else
    advance  = scanning && (!word_nz || !full);
`endif
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid)     state_d = S_SCAN;
      S_SCAN:  if (advance && last)  state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready = (state_q == S_IDLE);
    busy         = (state_q == S_SCAN);
  end

  always_comb begin
    snap_d       = snap_q;
    idx_d        = idx_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    move_count_d = move_count_q;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
    drop_count_d = drop_count_q;
`endif

    if (accept) begin
      snap_d = bus.moves_in;
      idx_d  = '0;
    end
    if (advance) idx_d = last ? '0 : idx_q + IDX_W'(1);

    if (push) begin
      mem_d[wr_ptr_q] = cur_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (move_count_q != {CNT_W{1'b1}}) move_count_d = move_count_q + CNT_W'(1);
    end
`ifdef MOVE_LIST_DROP_ON_FULL_EN
    if (drop && (drop_count_q != {CNT_W{1'b1}})) drop_count_d = drop_count_q + CNT_W'(1);
`endif
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Stale FIFO contents are harmless: out_move is masked while empty
    if (clear) begin
      idx_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      move_count_d = '0;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
      drop_count_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      idx_q        <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      move_count_q <= '0;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
      drop_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      move_count_q <= move_count_d;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
      drop_count_q <= drop_count_d;
`endif
    end
  end

  always_comb begin
    bus.out_valid = !empty;
    bus.out_move  = empty ? '0 : mem_q[rd_ptr_q];
    fifo_level    = level_q;
    move_count    = move_count_q;
`ifdef MOVE_LIST_DROP_ON_FULL_EN
    drop_count    = drop_count_q;
`endif
  end

endmodule

`default_nettype wire
